// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester (I/D) and memory-slave signals shared by mem_bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic [DATA_W-1:0] i_rdata_o;
  logic              i_ack_o;
  logic              i_err_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [3:0]        d_sel_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ack_o;
  logic              d_err_o;

  logic              s_stb_o;
  logic              s_we_o;
  logic [3:0]        s_sel_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_wdata_o;
  logic [DATA_W-1:0] s_rdata_i;
  logic              s_ack_i;

  logic              stallreq_o;

  modport slave (
    input  i_req_i, i_addr_i,
    input  d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    input  s_rdata_i, s_ack_i,
    output i_rdata_o, i_ack_o, i_err_o,
    output d_rdata_o, d_ack_o, d_err_o,
    output s_stb_o, s_we_o, s_sel_o, s_addr_o, s_wdata_o,
    output stallreq_o
  );

  modport master (
    output i_req_i, i_addr_i,
    output d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    output s_rdata_i, s_ack_i,
    input  i_rdata_o, i_ack_o, i_err_o,
    input  d_rdata_o, d_ack_o, d_err_o,
    input  s_stb_o, s_we_o, s_sel_o, s_addr_o, s_wdata_o,
    input  stallreq_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one stb/ack memory port between instruction fetch (I) and data (D),
// one registered transaction at a time, with a per-transaction timeout.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.slave    bus
);

  localparam logic [15:0] CNT_LAST = 16'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;

  logic              r_stb;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ack;
  logic              r_i_err;
  logic              r_d_ack;
  logic              r_d_err;
  logic              r_last_d;
  logic [15:0]       r_cnt;

  logic              w_i_req;
  logic              w_d_req;
  logic              w_ack;
  logic              w_tmo;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_done;
  logic              w_busy_d;

  // A requester still holds req during its own ack/err cycle; that is not a new request.
  assign w_i_req  = bus.i_req_i & ~r_i_ack & ~r_i_err;
  assign w_d_req  = bus.d_req_i & ~r_d_ack & ~r_d_err;
  assign w_ack    = r_stb & bus.s_ack_i;
  assign w_tmo    = r_stb & ~bus.s_ack_i & (r_cnt == CNT_LAST);
  assign w_busy_d = (r_state == BUSY_D);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_req && (!w_i_req || !r_last_d)) w_state_nxt = BUSY_D;
        else if (w_i_req)                       w_state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (w_ack || w_tmo) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_d = (w_state_nxt == BUSY_D);
        w_grant_i = (w_state_nxt == BUSY_I);
      end
      BUSY_I, BUSY_D: w_done = w_ack | w_tmo;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_last_d  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_i_ack <= 1'b0;
      r_i_err <= 1'b0;
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;
      if (w_grant_d) begin
        r_stb    <= 1'b1;
        r_we     <= bus.d_we_i;
        r_sel    <= bus.d_sel_i;
        r_addr   <= bus.d_addr_i;
        r_wdata  <= bus.d_wdata_i;
        r_cnt    <= '0;
        r_last_d <= 1'b1;
      end else if (w_grant_i) begin
        r_stb    <= 1'b1;
        r_we     <= 1'b0;
        r_sel    <= 4'hF;
        r_addr   <= bus.i_addr_i;
        r_wdata  <= '0;
        r_cnt    <= '0;
        r_last_d <= 1'b0;
      end else if (w_done) begin
        r_stb <= 1'b0;
        if (w_ack) begin
          if (w_busy_d) begin
            r_d_rdata <= bus.s_rdata_i;
            r_d_ack   <= 1'b1;
          end else begin
            r_i_rdata <= bus.s_rdata_i;
            r_i_ack   <= 1'b1;
          end
        end else if (w_busy_d) begin
          r_d_err <= 1'b1;
        end else begin
          r_i_err <= 1'b1;
        end
      end else if (r_stb) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign bus.s_stb_o    = r_stb;
  assign bus.s_we_o     = r_we;
  assign bus.s_sel_o    = r_sel;
  assign bus.s_addr_o   = r_addr;
  assign bus.s_wdata_o  = r_wdata;
  assign bus.i_rdata_o  = r_i_rdata;
  assign bus.i_ack_o    = r_i_ack;
  assign bus.i_err_o    = r_i_err;
  assign bus.d_rdata_o  = r_d_rdata;
  assign bus.d_ack_o    = r_d_ack;
  assign bus.d_err_o    = r_d_err;
  assign bus.stallreq_o = (bus.i_req_i & ~r_i_ack) | (bus.d_req_i & ~r_d_ack);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single access, contention, fairness,
// timeout, ack on the last counted cycle, and reset during a transaction.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_d_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_req_i = 0; bus.i_addr_i = 0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_sel_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0;
    bus.s_rdata_i = 0; bus.s_ack_i = 0;
    tick(); tick();
    total++; if (bus.s_stb_o !== 1'b0) begin bad++; $display("FAIL rst_stb got=%0b want=0", bus.s_stb_o); end
    total++; if ({bus.i_ack_o, bus.i_err_o, bus.d_ack_o, bus.d_err_o} !== 4'b0) begin
      bad++; $display("FAIL rst_pulses got=%b want=0000", {bus.i_ack_o, bus.i_err_o, bus.d_ack_o, bus.d_err_o}); end
    total++; if ({bus.i_rdata_o, bus.d_rdata_o} !== 64'h0) begin
      bad++; $display("FAIL rst_rdata got=%h want=0", {bus.i_rdata_o, bus.d_rdata_o}); end
    total++; if (bus.stallreq_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", bus.stallreq_o); end
    rst = 1'b1;
    tick();
  endtask

  // T1: single D read, slave acks two cycles after the strobe rises.
  task automatic test_d_read();
    bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'h0BAD0BAD;
    tick();
    bus.s_ack_i = 1'b0;
    tick();
    total++; if (bus.d_ack_o !== 1'b0 || bus.d_rdata_o !== 32'h0) begin
      bad++; $display("FAIL t1_idle_ack got=%0b/%h want=0/0", bus.d_ack_o, bus.d_rdata_o); end
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_sel_i = 4'hF; bus.d_addr_i = 32'h100; bus.d_wdata_i = 32'h0;
    #1;
    total++; if (bus.stallreq_o !== 1'b1 || bus.s_stb_o !== 1'b0) begin
      bad++; $display("FAIL t1_req got stall=%0b stb=%0b want 1/0", bus.stallreq_o, bus.s_stb_o); end
    tick();
    total++; if (bus.s_stb_o !== 1'b1 || bus.s_addr_o !== 32'h100 || bus.s_we_o !== 1'b0) begin
      bad++; $display("FAIL t1_stb got stb=%0b addr=%h we=%0b want 1/100/0", bus.s_stb_o, bus.s_addr_o, bus.s_we_o); end
    tick();
    total++; if (bus.d_ack_o !== 1'b0 || bus.stallreq_o !== 1'b1) begin
      bad++; $display("FAIL t1_wait got ack=%0b stall=%0b want 0/1", bus.d_ack_o, bus.stallreq_o); end
    tick();
    bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'hDEADBEEF;
    tick();
    total++; if (bus.d_ack_o !== 1'b1 || bus.d_rdata_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL t1_ack got ack=%0b rdata=%h want 1/deadbeef", bus.d_ack_o, bus.d_rdata_o); end
    total++; if (bus.s_stb_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin
      bad++; $display("FAIL t1_done got stb=%0b stall=%0b want 0/0", bus.s_stb_o, bus.stallreq_o); end
    bus.d_req_i = 1'b0; bus.s_ack_i = 1'b0;
    tick();
    total++; if (bus.d_ack_o !== 1'b0 || bus.d_rdata_o !== 32'hDEADBEEF || bus.s_stb_o !== 1'b0) begin
      bad++; $display("FAIL t1_after got ack=%0b rdata=%h stb=%0b want 0/deadbeef/0", bus.d_ack_o, bus.d_rdata_o, bus.s_stb_o); end
    exp_d_rdata = 32'hDEADBEEF;
  endtask

  // T2: I and D request together after reset; D first, then I with a 1-cycle strobe gap.
  task automatic test_both_same_cycle();
    rst = 1'b0; tick(); rst = 1'b1; tick();
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_sel_i = 4'h5; bus.d_addr_i = 32'h200; bus.d_wdata_i = 32'hFFFF0000;
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h300;
    tick();
    total++; if (bus.s_stb_o !== 1'b1 || bus.s_addr_o !== 32'h200 || bus.s_we_o !== 1'b1 || bus.s_sel_o !== 4'h5) begin
      bad++; $display("FAIL t2_d_grant got stb=%0b addr=%h we=%0b sel=%h want 1/200/1/5", bus.s_stb_o, bus.s_addr_o, bus.s_we_o, bus.s_sel_o); end
    bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'h11111111;
    tick();
    total++; if (bus.d_ack_o !== 1'b1 || bus.i_ack_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.d_rdata_o !== 32'h11111111) begin
      bad++; $display("FAIL t2_d_ack got d=%0b i=%0b stb=%0b rdata=%h want 1/0/0/11111111", bus.d_ack_o, bus.i_ack_o, bus.s_stb_o, bus.d_rdata_o); end
    bus.d_req_i = 1'b0; bus.s_ack_i = 1'b0;
    tick();
    total++; if (bus.s_stb_o !== 1'b1 || bus.s_addr_o !== 32'h300) begin
      bad++; $display("FAIL t2_i_grant got stb=%0b addr=%h want 1/300", bus.s_stb_o, bus.s_addr_o); end
    total++; if (bus.s_we_o !== 1'b0 || bus.s_sel_o !== 4'hF || bus.s_wdata_o !== 32'h0) begin
      bad++; $display("FAIL t2_i_fields got we=%0b sel=%h wdata=%h want 0/f/0", bus.s_we_o, bus.s_sel_o, bus.s_wdata_o); end
    bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'h22222222;
    tick();
    total++; if (bus.i_ack_o !== 1'b1 || bus.d_ack_o !== 1'b0 || bus.i_rdata_o !== 32'h22222222) begin
      bad++; $display("FAIL t2_i_ack got i=%0b d=%0b rdata=%h want 1/0/22222222", bus.i_ack_o, bus.d_ack_o, bus.i_rdata_o); end
    bus.i_req_i = 1'b0; bus.s_ack_i = 1'b0;
    tick();
    exp_d_rdata = 32'h11111111;
  endtask

  // T3: both requesters held continuously; grants must alternate D,I,D,I.
  task automatic test_back_to_back();
    int n;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_sel_i = 4'hF; bus.d_addr_i = 32'h200; bus.d_wdata_i = 32'h0;
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h300;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (bus.s_stb_o !== 1'b1 && n < 8) begin tick(); n++; end
      total++; if (bus.s_stb_o !== 1'b1) begin bad++; $display("FAIL t3_stb_timeout k=%0d got stb=%0b want 1", k, bus.s_stb_o); end
      total++; if (n != 1) begin bad++; $display("FAIL t3_gap k=%0d got %0d cycles want 1", k, n); end
      total++; if (bus.s_addr_o !== ((k % 2 == 0) ? 32'h200 : 32'h300)) begin
        bad++; $display("FAIL t3_order k=%0d got addr=%h want %h", k, bus.s_addr_o, (k % 2 == 0) ? 32'h200 : 32'h300); end
      bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'hA0000000 + 32'(k);
      tick();
      if (k % 2 == 0) begin
        total++; if (bus.d_ack_o !== 1'b1 || bus.i_ack_o !== 1'b0 || bus.d_rdata_o !== 32'hA0000000 + 32'(k)) begin
          bad++; $display("FAIL t3_d_ack k=%0d got d=%0b i=%0b rdata=%h", k, bus.d_ack_o, bus.i_ack_o, bus.d_rdata_o); end
      end else begin
        total++; if (bus.i_ack_o !== 1'b1 || bus.d_ack_o !== 1'b0 || bus.i_rdata_o !== 32'hA0000000 + 32'(k)) begin
          bad++; $display("FAIL t3_i_ack k=%0d got i=%0b d=%0b rdata=%h", k, bus.i_ack_o, bus.d_ack_o, bus.i_rdata_o); end
      end
      bus.s_ack_i = 1'b0;
    end
    bus.d_req_i = 1'b0; bus.i_req_i = 1'b0;
    tick();
    total++; if (bus.s_stb_o !== 1'b0) begin bad++; $display("FAIL t3_idle got stb=%0b want 0", bus.s_stb_o); end
    exp_d_rdata = 32'hA0000002;
  endtask

  // T4: slave never acks; D drops its request mid-way; error still pulses at stb+8.
  task automatic test_timeout();
    bus.s_ack_i = 1'b0; bus.s_rdata_i = 32'h5A5A5A5A;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_sel_i = 4'h3; bus.d_addr_i = 32'h400; bus.d_wdata_i = 32'h12345678;
    tick();
    total++; if (bus.s_stb_o !== 1'b1 || bus.s_we_o !== 1'b1 || bus.s_sel_o !== 4'h3 || bus.s_wdata_o !== 32'h12345678) begin
      bad++; $display("FAIL t4_stb got stb=%0b we=%0b sel=%h wdata=%h", bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.s_wdata_o); end
    for (int j = 0; j < 8; j++) begin
      total++; if (bus.d_err_o !== 1'b0 || bus.s_stb_o !== 1'b1) begin
        bad++; $display("FAIL t4_wait j=%0d got err=%0b stb=%0b want 0/1", j, bus.d_err_o, bus.s_stb_o); end
      if (j == 3) bus.d_req_i = 1'b0;
      tick();
    end
    total++; if (bus.d_err_o !== 1'b1 || bus.d_ack_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin
      bad++; $display("FAIL t4_err got err=%0b ack=%0b stb=%0b want 1/0/0", bus.d_err_o, bus.d_ack_o, bus.s_stb_o); end
    total++; if (bus.d_rdata_o !== exp_d_rdata) begin
      bad++; $display("FAIL t4_rdata got=%h want=%h", bus.d_rdata_o, exp_d_rdata); end
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h500;
    tick();
    total++; if (bus.d_err_o !== 1'b0 || bus.s_stb_o !== 1'b1 || bus.s_addr_o !== 32'h500) begin
      bad++; $display("FAIL t4_idle got err=%0b stb=%0b addr=%h want 0/1/500", bus.d_err_o, bus.s_stb_o, bus.s_addr_o); end
    bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'h33333333;
    tick();
    total++; if (bus.i_ack_o !== 1'b1 || bus.i_rdata_o !== 32'h33333333) begin
      bad++; $display("FAIL t4_i_ack got ack=%0b rdata=%h want 1/33333333", bus.i_ack_o, bus.i_rdata_o); end
    bus.i_req_i = 1'b0; bus.s_ack_i = 1'b0;
    tick();
  endtask

  // T5: ack arrives on the last counted cycle; ack wins over timeout.
  task automatic test_ack_at_limit();
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_sel_i = 4'hF; bus.d_addr_i = 32'h600;
    tick();
    for (int j = 0; j < 7; j++) tick();
    total++; if (bus.s_stb_o !== 1'b1 || bus.d_err_o !== 1'b0) begin
      bad++; $display("FAIL t5_hold got stb=%0b err=%0b want 1/0", bus.s_stb_o, bus.d_err_o); end
    bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'h77777777;
    tick();
    total++; if (bus.d_ack_o !== 1'b1 || bus.d_err_o !== 1'b0 || bus.d_rdata_o !== 32'h77777777) begin
      bad++; $display("FAIL t5_ack got ack=%0b err=%0b rdata=%h want 1/0/77777777", bus.d_ack_o, bus.d_err_o, bus.d_rdata_o); end
    bus.d_req_i = 1'b0; bus.s_ack_i = 1'b0;
    tick();
    total++; if (bus.d_ack_o !== 1'b0 || bus.d_err_o !== 1'b0) begin
      bad++; $display("FAIL t5_after got ack=%0b err=%0b want 0/0", bus.d_ack_o, bus.d_err_o); end
  endtask

  // T6: reset during BUSY_I kills the strobe at once; fetch is re-served after release.
  task automatic test_reset_mid();
    bus.i_req_i = 1'b1; bus.i_addr_i = 32'h800;
    tick();
    total++; if (bus.s_stb_o !== 1'b1 || bus.s_addr_o !== 32'h800) begin
      bad++; $display("FAIL t6_stb got stb=%0b addr=%h want 1/800", bus.s_stb_o, bus.s_addr_o); end
    tick();
    rst = 1'b0;
    #1;
    total++; if (bus.s_stb_o !== 1'b0) begin bad++; $display("FAIL t6_async got stb=%0b want 0", bus.s_stb_o); end
    bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'hBADBAD00;
    tick();
    total++; if (bus.i_ack_o !== 1'b0 || bus.i_err_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin
      bad++; $display("FAIL t6_in_rst got ack=%0b err=%0b stb=%0b want 0/0/0", bus.i_ack_o, bus.i_err_o, bus.s_stb_o); end
    bus.s_ack_i = 1'b0;
    rst = 1'b1;
    tick();
    total++; if (bus.s_stb_o !== 1'b1 || bus.s_addr_o !== 32'h800) begin
      bad++; $display("FAIL t6_reserve got stb=%0b addr=%h want 1/800", bus.s_stb_o, bus.s_addr_o); end
    bus.s_ack_i = 1'b1; bus.s_rdata_i = 32'h88888888;
    tick();
    total++; if (bus.i_ack_o !== 1'b1 || bus.i_rdata_o !== 32'h88888888) begin
      bad++; $display("FAIL t6_ack got ack=%0b rdata=%h want 1/88888888", bus.i_ack_o, bus.i_rdata_o); end
    bus.i_req_i = 1'b0; bus.s_ack_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_d_read();
    test_both_same_cycle();
    test_back_to_back();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
